cla_serial_adder: RTL

Multi-cycle carry-lookahead adder that sums two WIDTH-bit operands GROUP bits per clock, using a registered carry between slices. It sits directly downstream of the `fulladder` cell: it instantiates GROUP `fulladder` cells per slice and consumes their `s`/`p`/`g` outputs in a lookahead carry network. It presents a valid/ready request side and a valid/ready result side to the surrounding datapath.

---
 rtl/cla_pkg.sv | 15 +
 rtl/cla_group.sv | 59 +++++
 rtl/fulladder.sv | 20 ++
 rtl/cla_serial_adder.sv | 104 ++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder.
//   - FSM state encoding (IDLE / ADD / DONE)
//   - default operand width and slice width
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GROUP = 4;

  typedef logic [1:0] cla_state_t;

  localparam cla_state_t S_IDLE = 2'd0;
  localparam cla_state_t S_ADD  = 2'd1;
  localparam cla_state_t S_DONE = 2'd2;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice, purely combinational.
//   a, b  : slice operands
//   cin   : carry into the slice LSB
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow)
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  for (genvar i = 0; i < GROUP; i++) begin : g_fa
    fulladder u_fa (
      .a (a[i]),
      .b (b[i]),
      .c (c[i]),
      .s (sum[i]),
      .p (p[i]),
      .g (g[i])
    );
  end

  // Each carry is a flat sum of products over g/p and the slice carry-in:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  // Every product term is built from primary p/g only, never from c[i].
  always_comb begin
    logic term;
    logic acc;
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      term = cin;
      for (int unsigned k = 0; k <= i; k++) term = term & p[k];
      acc = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell exposing propagate/generate for lookahead use.
//   a, b : operand bits
//   c    : carry in
//   s    : sum bit (a ^ b ^ c)
//   p    : propagate (a | b)
//   g    : generate  (a & b)
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic p,
  output logic g
);

  assign s = a ^ b ^ c;
  assign p = a | b;
  assign g = a & b;

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands GROUP bits per clock using
// a lookahead slice and a registered carry between slices.
//   clk, rst_n               : clock, synchronous active-low reset
//   start_valid/start_ready  : request handshake; a, b, cin sampled on accept
//   done_valid/done_ready    : result handshake
//   sum                      : registered WIDTH-bit sum
//   cout                     : carry out of bit WIDTH-1 (unsigned)
//   overflow                 : two's-complement overflow
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / GROUP;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  cla_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;

  logic [GROUP-1:0] slice_a;
  logic [GROUP-1:0] slice_b;
  logic [GROUP-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  assign slice_a = opa[cnt*GROUP +: GROUP];
  assign slice_b = opb[cnt*GROUP +: GROUP];

  cla_group #(
    .GROUP (GROUP)
  ) u_group (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // Handshake outputs depend on registered state only.
  assign start_ready = (state == S_IDLE);
  assign done_valid  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          sum[cnt*GROUP +: GROUP] <= slice_sum;
          carry                   <= slice_cout;
          if (cnt == LAST) begin
            cout     <= slice_cout;
            // Carry into the final slice MSB is the carry into bit WIDTH-1.
            overflow <= slice_cmsb ^ slice_cout;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
